// File: rtl/word_endpoint_detector.sv
// Word endpoint detector: rectify -> moving-average envelope -> hysteresis FSM.
// Emits one start/end index pair per detected word, with pre-roll on the onset,
// hangover bridging of short gaps, minimum-length rejection and utterance
// boundaries marked by ilast.
module word_endpoint_detector #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 32,
  parameter int AVG_LOG2 = 6,
  parameter int HANG     = 2048,
  parameter int MIN_LEN  = 1024,
  parameter int PRE_ROLL = 256
) (
  input  logic              iclk,
  input  logic              irstn,
  input  logic              ivalid,
  input  logic [DATA_W-1:0] idata,
  input  logic [IDX_W-1:0]  iidx,
  input  logic              ilast,
  input  logic [DATA_W-1:0] ithresh,
  output logic              oavg_valid,
  output logic [DATA_W-1:0] oavg,
  output logic [IDX_W-1:0]  oavg_idx,
  output logic              ovalid,
  output logic [IDX_W-1:0]  ostart_idx,
  output logic [IDX_W-1:0]  oend_idx,
  output logic              obusy
);

  localparam int WIN    = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int HCW    = $clog2(HANG + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HANG} state_t;

  // Magnitude with the most negative code clamped to the most positive one.
  function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] mag;
    if (x == $signed({1'b1, {(DATA_W-1){1'b0}}})) mag = $signed({1'b0, {(DATA_W-1){1'b1}}});
    else if (x < 0)                                mag = -x;
    else                                           mag = x;
    return $unsigned(mag);
  endfunction

  // Window average by truncating shift of the running sum.
  function automatic logic [DATA_W-1:0] envelope(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  // Onset index moved back by the pre-roll, clamped at address 0.
  function automatic logic [IDX_W-1:0] preroll(input logic [IDX_W-1:0] idx);
    if (idx >= IDX_W'(PRE_ROLL)) return idx - IDX_W'(PRE_ROLL);
    return '0;
  endfunction

  logic [1:0] rst_pipe;
  logic       rst_n;

  // Reset asserts immediately and releases two clock edges after irstn rises.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // ---- Stage p0: accepted sample ----
  logic                     vld_p0, last_p0;
  logic signed [DATA_W-1:0] data_p0;
  logic [IDX_W-1:0]         idx_p0;

  // Strobe and utterance marker of the captured sample.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= ivalid;
      last_p0 <= ivalid & ilast;
    end
  end

  // Sample payload, held across bubbles.
  always_ff @(posedge iclk) begin
    if (ivalid) begin
      data_p0 <= $signed(idata);
      idx_p0  <= iidx;
    end
  end

  // ---- Stage p1: rectified sample ----
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] rect_p1;
  logic [IDX_W-1:0]  idx_p1;

  // Strobe and utterance marker follow the sample into the rectifier stage.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) last_p1 <= last_p0;
    end
  end

  // Rectified magnitude and its index.
  always_ff @(posedge iclk) begin
    if (vld_p0) begin
      rect_p1 <= rectify(data_p0);
      idx_p1  <= idx_p0;
    end
  end

  // ---- Stage p2: moving-average envelope ----
  logic              vld_p2, last_p2;
  logic [DATA_W-1:0] avg_p2;
  logic [IDX_W-1:0]  idx_p2;
  logic [SUM_W-1:0]  sum, sum_nx;
  logic [FILL_W-1:0] fill;
  logic [AVG_LOG2-1:0] ptr;
  logic [DATA_W-1:0] dline [WIN];
  logic [DATA_W-1:0] oldest;

  // Oldest window entry counts as zero until the window has filled.
  always_comb begin
    oldest = (fill == FILL_W'(WIN)) ? dline[ptr] : '0;
    sum_nx = sum + SUM_W'(rect_p1) - SUM_W'(oldest);
  end

  // Running sum, fill level and write pointer; all restart after an ilast sample.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      avg_p2  <= '0;
      idx_p2  <= '0;
      sum     <= '0;
      fill    <= '0;
      ptr     <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        avg_p2  <= envelope(sum_nx);
        idx_p2  <= idx_p1;
        last_p2 <= last_p1;
        if (last_p1) begin
          sum  <= '0;
          fill <= '0;
          ptr  <= '0;
        end else begin
          sum <= sum_nx;
          ptr <= ptr + 1'b1;
          if (fill != FILL_W'(WIN)) fill <= fill + 1'b1;
        end
      end
    end
  end

  // Delay line of rectified samples; stale contents are masked by the fill level.
  always_ff @(posedge iclk) begin
    if (vld_p1) dline[ptr] <= rect_p1;
  end

  assign oavg_valid = vld_p2;
  assign oavg       = avg_p2;
  assign oavg_idx   = idx_p2;

  // ---- Stage p3: hysteresis word FSM ----
  state_t           state, state_nx;
  logic [IDX_W-1:0] start_r, start_nx, last_ab, last_ab_nx;
  logic [IDX_W-1:0] fin_start, fin_end, word_len;
  logic [HCW-1:0]   hang_cnt, hang_cnt_nx;
  logic             above, finish, ovalid_nx;
  logic             ovalid_p3;
  logic [IDX_W-1:0] ostart_p3, oend_p3;

  // Next state, word bounds and the finish/accept decision per envelope sample.
  always_comb begin
    state_nx    = state;
    start_nx    = start_r;
    last_ab_nx  = last_ab;
    hang_cnt_nx = hang_cnt;
    finish      = 1'b0;
    fin_start   = start_r;
    fin_end     = last_ab;
    above       = avg_p2 > ithresh;
    if (vld_p2) begin
      case (state)
        ST_IDLE: begin
          if (above) begin
            start_nx   = preroll(idx_p2);
            last_ab_nx = idx_p2;
            fin_start  = preroll(idx_p2);
            fin_end    = idx_p2;
            if (last_p2) finish   = 1'b1;
            else         state_nx = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (above) last_ab_nx = idx_p2;
          if (last_p2) begin
            finish  = 1'b1;
            fin_end = idx_p2;
          end else if (!above) begin
            hang_cnt_nx = HCW'(1);
            if (HANG == 1) finish   = 1'b1;
            else           state_nx = ST_HANG;
          end
        end
        ST_HANG: begin
          if (last_p2) begin
            finish = 1'b1;
          end else if (above) begin
            state_nx   = ST_ACTIVE;
            last_ab_nx = idx_p2;
          end else begin
            hang_cnt_nx = hang_cnt + 1'b1;
            if (hang_cnt_nx == HCW'(HANG)) finish = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
      if (finish) state_nx = ST_IDLE;
    end
    word_len  = fin_end - fin_start + 1'b1;
    ovalid_nx = finish && (word_len >= IDX_W'(MIN_LEN));
  end

  // FSM state, word tracking and the held output pair.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_r   <= '0;
      last_ab   <= '0;
      hang_cnt  <= '0;
      ovalid_p3 <= 1'b0;
      ostart_p3 <= '0;
      oend_p3   <= '0;
    end else begin
      state     <= state_nx;
      start_r   <= start_nx;
      last_ab   <= last_ab_nx;
      hang_cnt  <= hang_cnt_nx;
      ovalid_p3 <= ovalid_nx;
      if (ovalid_nx) begin
        ostart_p3 <= fin_start;
        oend_p3   <= fin_end;
      end
    end
  end

  assign ovalid     = ovalid_p3;
  assign ostart_idx = ostart_p3;
  assign oend_idx   = oend_p3;
  assign obusy      = (state != ST_IDLE);

endmodule

// File: tb/tb_word_endpoint_detector.sv
// Bench for word_endpoint_detector: directed scenarios plus random streams,
// checked cycle by cycle against a window/grouping reference model.
module tb_word_endpoint_detector;

  localparam int DW   = 16;
  localparam int IW   = 32;
  localparam int HG   = 8;
  localparam int ML   = 8;
  localparam int PR   = 2;
  localparam int MAXN = 1024;

  logic          iclk = 1'b0;
  logic          irstn;
  logic          ivalid;
  logic [DW-1:0] idata;
  logic [IW-1:0] iidx;
  logic          ilast;
  logic [DW-1:0] ithresh;
  logic          oavg_valid;
  logic [DW-1:0] oavg;
  logic [IW-1:0] oavg_idx;
  logic          ovalid;
  logic [IW-1:0] ostart_idx;
  logic [IW-1:0] oend_idx;
  logic          obusy;

  word_endpoint_detector #(
    .DATA_W(DW), .IDX_W(IW), .AVG_LOG2(2), .HANG(HG), .MIN_LEN(ML), .PRE_ROLL(PR)
  ) dut (
    .iclk(iclk), .irstn(irstn), .ivalid(ivalid), .idata(idata), .iidx(iidx),
    .ilast(ilast), .ithresh(ithresh), .oavg_valid(oavg_valid), .oavg(oavg),
    .oavg_idx(oavg_idx), .ovalid(ovalid), .ostart_idx(ostart_idx),
    .oend_idx(oend_idx), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;

  int  n;
  int  sdata [MAXN];
  bit  slast [MAXN];
  int  env [MAXN];
  int  obs_env [MAXN];
  int  w_first[$], w_start[$], w_end[$], w_fin[$];
  bit  w_keep[$];
  int  ov_start[$], ov_end[$], ov_at[$];
  bit  saw_busy;
  logic [IW-1:0] exp_s, exp_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rect(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit busy_at(input int k);
    for (int i = 0; i < w_first.size(); i++)
      if (w_first[i] <= k && k < w_fin[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Envelope = mean of the last 4 samples of the current utterance; words are
  // runs of above-threshold samples whose gaps are shorter than HG, cut at ilast.
  task automatic build_model();
    int a, b, sum, i, j, x, prev, e, s;
    int above[$];
    w_first.delete(); w_start.delete(); w_end.delete(); w_fin.delete(); w_keep.delete();
    a = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && slast[k-1]) a = k;
      sum = 0;
      for (int q = (k - 3 > a) ? k - 3 : a; q <= k; q++) sum += rect(sdata[q]);
      env[k] = sum / 4;
    end
    a = 0;
    while (a < n) begin
      b = a;
      while (b < n - 1 && !slast[b]) b++;
      above.delete();
      for (int k = a; k <= b; k++) if (env[k] > int'(ithresh)) above.push_back(k);
      i = 0;
      while (i < above.size()) begin
        j = i;
        while (j + 1 < above.size() && above[j+1] - above[j] <= HG) j++;
        x = above[j];
        if (slast[b] && x + HG >= b) begin
          prev = (x == b) ? ((j > i) ? above[j-1] : -1) : x;
          e = (prev < 0 || prev == b - 1) ? b : prev;
          w_fin.push_back(b);
        end else begin
          e = x;
          w_fin.push_back(x + HG);
        end
        s = (above[i] >= PR) ? above[i] - PR : 0;
        w_first.push_back(above[i]);
        w_start.push_back(s);
        w_end.push_back(e);
        w_keep.push_back(e - s + 1 >= ML);
        i = j + 1;
      end
      a = b + 1;
    end
  endtask

  task automatic clear_stream(input int len);
    n = len;
    for (int k = 0; k < MAXN; k++) begin
      sdata[k] = 0;
      slast[k] = 1'b0;
    end
    slast[len-1] = 1'b1;
  endtask

  task automatic gen_random(input int len);
    int k, loud, runlen;
    clear_stream(len);
    k = 0;
    while (k < n) begin
      loud   = int'($urandom_range(0, 1));
      runlen = int'($urandom_range(1, 30));
      for (int r = 0; r < runlen && k < n; r++) begin
        if (loud != 0)
          sdata[k] = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 3000)) - 1500;
        else
          sdata[k] = int'($urandom_range(0, 80)) - 40;
        slast[k] = ($urandom_range(0, 59) == 0);
        k++;
      end
    end
    slast[n-1] = 1'b1;
  endtask

  task automatic run_stream(input bit gaps);
    int k, wi, cyc, flush, c2, c3;
    int hist[$];
    bit v, exp_ov, exp_busy;
    build_model();
    ov_start.delete(); ov_end.delete(); ov_at.delete();
    for (int q = 0; q < MAXN; q++) obs_env[q] = -1;
    saw_busy = 1'b0;
    k = 0; wi = 0; flush = 0; exp_busy = 1'b0;
    while (flush < 6) begin
      v = (k < n) && !(gaps && $urandom_range(0, 3) == 0);
      ivalid = v;
      if (v) begin
        idata = sdata[k][DW-1:0];
        ilast = slast[k];
        iidx  = IW'(k);
      end else begin
        idata = '0;
        ilast = 1'b0;
      end
      @(posedge iclk); #1;
      hist.push_back(v ? k : -1);
      if (v) k++;
      else if (k >= n) flush++;
      cyc = hist.size() - 1;
      c2 = (cyc >= 2) ? hist[cyc-2] : -1;
      c3 = (cyc >= 3) ? hist[cyc-3] : -1;
      chk("oavg_valid", oavg_valid, c2 >= 0);
      if (c2 >= 0) begin
        chk("oavg", oavg, env[c2]);
        chk("oavg_idx", oavg_idx, c2);
        obs_env[c2] = int'(oavg);
      end
      exp_ov = 1'b0;
      if (c3 >= 0) begin
        exp_busy = busy_at(c3);
        while (wi < w_fin.size() && w_fin[wi] == c3) begin
          if (w_keep[wi]) begin
            exp_ov = 1'b1;
            exp_s  = IW'(w_start[wi]);
            exp_e  = IW'(w_end[wi]);
          end
          wi++;
        end
      end
      chk("ovalid", ovalid, exp_ov);
      chk("ostart_idx", ostart_idx, exp_s);
      chk("oend_idx", oend_idx, exp_e);
      chk("obusy", obusy, exp_busy);
      if (ovalid) begin
        ov_start.push_back(int'(ostart_idx));
        ov_end.push_back(int'(oend_idx));
        ov_at.push_back(c3);
      end
      if (obusy) saw_busy = 1'b1;
    end
    ivalid = 1'b0;
    ilast  = 1'b0;
    chk("words_closed", wi, w_fin.size());
  endtask

  initial begin
    irstn = 1'b0; ivalid = 1'b0; ilast = 1'b0; idata = '0; iidx = '0;
    ithresh = 16'd100; exp_s = '0; exp_e = '0;

    // Reset held with random traffic: every output stays at zero.
    for (int c = 0; c < 8; c++) begin
      ivalid = 1'b1;
      idata  = DW'($urandom);
      iidx   = IW'(c);
      ilast  = $urandom_range(0, 1) == 1;
      @(posedge iclk); #1;
      chk("rst_oavg_valid", oavg_valid, 0);
      chk("rst_oavg", oavg, 0);
      chk("rst_oavg_idx", oavg_idx, 0);
      chk("rst_ovalid", ovalid, 0);
      chk("rst_ostart", ostart_idx, 0);
      chk("rst_oend", oend_idx, 0);
      chk("rst_obusy", obusy, 0);
    end
    ivalid = 1'b0; ilast = 1'b0;
    irstn = 1'b1;
    repeat (4) @(posedge iclk);
    #1;

    // Saturating rectifier ramp on full-scale negative input.
    clear_stream(8);
    for (int k = 0; k < 8; k++) sdata[k] = -32768;
    run_stream(1'b0);
    chk("sat_env0", obs_env[0], 8191);
    chk("sat_env1", obs_env[1], 16383);
    chk("sat_env2", obs_env[2], 24575);
    chk("sat_env3", obs_env[3], 32767);
    chk("sat_env7", obs_env[7], 32767);
    chk("sat_words", ov_start.size(), 1);
    chk("sat_end", (ov_end.size() > 0) ? ov_end[0] : -1, 7);

    // Single word with hangover close.
    clear_stream(60);
    for (int k = 20; k < 40; k++) sdata[k] = 1000;
    run_stream(1'b0);
    chk("word_count", ov_start.size(), 1);
    chk("word_start", (ov_start.size() > 0) ? ov_start[0] : -1, 18);
    chk("word_end", (ov_end.size() > 0) ? ov_end[0] : -1, 42);
    chk("word_at", (ov_at.size() > 0) ? ov_at[0] : -1, 50);

    // Short burst rejected by minimum length.
    clear_stream(40);
    sdata[20] = 1000;
    run_stream(1'b0);
    chk("short_count", ov_start.size(), 0);
    chk("short_saw_busy", saw_busy, 1);
    chk("short_idle", obusy, 0);

    // Gap shorter than the hangover bridged into one word.
    clear_stream(70);
    for (int k = 20; k < 30; k++) sdata[k] = 1000;
    for (int k = 35; k < 45; k++) sdata[k] = 1000;
    run_stream(1'b0);
    chk("gap_count", ov_start.size(), 1);
    chk("gap_start", (ov_start.size() > 0) ? ov_start[0] : -1, 18);
    chk("gap_end", (ov_end.size() > 0) ? ov_end[0] : -1, 47);

    // ilast cuts the word and restarts the window.
    clear_stream(70);
    for (int k = 1; k <= 40; k++) sdata[k] = 1000;
    slast[30] = 1'b1;
    run_stream(1'b0);
    chk("last_count", ov_start.size(), 2);
    chk("last_start", (ov_start.size() > 0) ? ov_start[0] : -1, 0);
    chk("last_end", (ov_end.size() > 0) ? ov_end[0] : -1, 30);
    chk("last_env30", obs_env[30], 1000);
    chk("last_env31", obs_env[31], 250);
    chk("last_start2", (ov_start.size() > 1) ? ov_start[1] : -1, 29);

    // Reset in the middle of a word loses it silently.
    for (int c = 0; c <= 50; c++) begin
      ivalid = 1'b1;
      idata  = (c < 25) ? DW'(1000) : '0;
      iidx   = IW'(c);
      ilast  = (c == 50);
      irstn  = !(c >= 25 && c < 28);
      @(posedge iclk); #1;
      if (c == 20) chk("mid_busy", obusy, 1);
      chk("mid_no_ovalid", ovalid, 0);
      if (c >= 25) chk("mid_idle", obusy, 0);
      if (c >= 25 && c < 28) chk("mid_rst_avgv", oavg_valid, 0);
    end
    ivalid = 1'b0; ilast = 1'b0;
    repeat (4) @(posedge iclk);
    #1;
    exp_s = '0; exp_e = '0;
    chk("mid_ostart", ostart_idx, 0);
    chk("mid_oend", oend_idx, 0);

    // Random utterances with bubbles and runtime thresholds.
    for (int r = 0; r < 3; r++) begin
      ithresh = DW'($urandom_range(60, 400));
      gen_random(400);
      run_stream(1'b1);
      chk("rand_idle", obusy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_endpoint_detector.md
# word_endpoint_detector

Parametrised successor to the rectify / moving-average / word-clip chain that feeds the framer. Takes a stream of signed audio samples with their memory indices, forms a rectified moving-average energy envelope over a configurable power-of-two window, and runs a hysteresis state machine that emits one start/end index pair per detected word. Adds pre-roll, hangover gap bridging, minimum-length rejection, runtime threshold and multi-word/utterance-boundary handling. Sits between the audio sample source and `frame`; `ovalid`/`ostart_idx`/`oend_idx` drive the framer's start/address inputs directly.

## Interface
- `DATA_W`, 16, sample width (signed two's complement)
- `IDX_W`, 32, sample index / address width
- `AVG_LOG2`, 6, log2 of moving-average window length (window = 2^AVG_LOG2 samples)
- `HANG`, 2048, consecutive below-threshold samples that end a word (≥1)
- `MIN_LEN`, 1024, minimum word length in samples (end-start+1); shorter words are discarded
- `PRE_ROLL`, 256, samples subtracted from the detected onset index
- `iclk`  in  1  clock, all logic on rising edge
- `irstn`  in  1  reset, asynchronous, active-low
- `ivalid`  in  1  sample strobe; no backpressure, accepted every cycle it is high
- `idata`  in  DATA_W  signed sample
- `iidx`  in  IDX_W  index of `idata`
- `ilast`  in  1  qualifies final sample of an utterance (valid only with `ivalid`)
- `ithresh`  in  DATA_W  unsigned energy threshold; hold stable while `obusy`
- `oavg_valid`  out  1  envelope sample strobe
- `oavg`  out  DATA_W  envelope value (unsigned)
- `oavg_idx`  out  IDX_W  index of `oavg`
- `ovalid`  out  1  one-cycle pulse: word detected
- `ostart_idx`  out  IDX_W  word start index, held until next `ovalid`
- `oend_idx`  out  IDX_W  word end index, held until next `ovalid`
- `obusy`  out  1  FSM not in IDLE

## Operation
- Stage 1 (rectify): |idata|, saturating: -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
- Stage 2 (average): delay line of 2^AVG_LOG2 rectified samples; running sum width DATA_W+AVG_LOG2, sum += new - oldest; oavg = sum >> AVG_LOG2 (truncate). Fill counter masks oldest to 0 until window is full, so the envelope ramps after reset and after each `ilast`.
- `ilast` sample: processed normally, then sum, fill counter and delay-line pointer clear (next sample starts a fresh window).
- "Above" means oavg > ithresh (strict). All comparisons per envelope sample.
- FSM states IDLE, ACTIVE, HANG:
  - IDLE: above -> ACTIVE; start = oavg_idx - PRE_ROLL, saturating at 0.
  - ACTIVE: above -> stay, last_above = oavg_idx; below -> HANG, hang_cnt = 1.
  - HANG: above -> ACTIVE, last_above = oavg_idx; below -> hang_cnt+1; when hang_cnt reaches HANG -> finish with end = last_above, go IDLE.
  - Envelope sample carrying `ilast` in ACTIVE (or causing IDLE->ACTIVE): finish with end = its idx. In HANG: finish with end = last_above. In IDLE: no action.
  - Finish: if end - start + 1 ≥ MIN_LEN, pulse `ovalid` and update ostart_idx/oend_idx; otherwise discard silently. FSM -> IDLE either way.
- Multiple words per utterance each produce their own pulse.
- Index arithmetic modulo 2^IDX_W except pre-roll saturation; indices assumed monotonic within an utterance.

## Timing
- Reset (async assert, sync deassert internally): all outputs 0, FSM IDLE, sum/fill/pointers 0.
- Sample accepted at edge t -> rectified at t+1 -> `oavg_valid`/`oavg`/`oavg_idx` at t+2 -> FSM update and `ovalid` at t+3.
- Fixed 3-cycle latency independent of `ivalid` gaps; bubbles propagate, no state advances on bubbles.
- `ovalid` high exactly one cycle; ostart/oend change only in that cycle.
- `obusy` reflects registered FSM state (rises t+3 after the onset sample).
- Reset mid-word: no `ovalid`, partial word lost.

## Test plan
Parameters AVG_LOG2=2, HANG=8, MIN_LEN=8, PRE_ROLL=2, ithresh=100, continuous ivalid, iidx = sample number from 0.
- Reset: hold irstn low, drive random samples -> all outputs 0; release -> first oavg_valid 2 cycles after first ivalid.
- Saturation: constant idata=-32768 -> oavg ramps 8191, 16383, 24575, 32767 then holds 32767.
- Word: 0 for idx 0-19, 1000 for 20-39, 0 after -> single ovalid 3 cycles after idx 50 accepted, ostart=18, oend=42.
- Short burst: 1000 at idx 20 only -> envelope above idx 20-23, length 6 < 8 -> no ovalid, obusy returns 0.
- Gap bridging: 1000 at 20-29, 0 at 30-34, 1000 at 35-44 -> one ovalid, ostart=18, oend=47.
- ilast: 1000 from idx 1 with ilast at idx 30 -> ovalid, ostart=0 (pre-roll saturated), oend=30; idx 31 value 1000 -> oavg 250 (window cleared); separately, irstn pulse at idx 25 of a word -> no ovalid.
